// File: rtl/dc_fifo_din_arbiter.sv
// Purpose: round-robin packet arbiter feeding the din side of a dual-clock FIFO.
//          It holds each grant from a packet's first beat to its last beat and tags every beat with its source.
// Latency: zero cycles; the forwarding path is combinational.
// Backpressure: out_ready goes straight to the selected requester's in_ready. A beat that is presented stays selected until it is taken.
//
// Ports:
//   clk, rst              write-domain clock, synchronous active-high reset
//   in_data/valid/last    per-requester beat bus; requester i uses in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready              per-requester accept; only the selected requester can see it high
//   out_data/last/id      beat to the FIFO din, tagged with the source index
//   out_valid, out_ready  handshake towards the FIFO (out_ready = FIFO not full)
//   busy                  high while a packet grant is held
module dc_fifo_din_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 10,
  parameter int ID_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [N_REQ-1:0]            in_valid,
  input  logic [N_REQ-1:0]            in_last,
  output logic [N_REQ-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic [ID_WIDTH-1:0]         out_id,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic [ID_WIDTH-1:0] winner;
  logic                winner_found;
  logic [ID_WIDTH-1:0] sel;
  logic                active;
  logic                hs;

  // Successor index, wrapping at N_REQ so that non-power-of-two counts never reach an unused index.
  function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] x);
    if (x == ID_WIDTH'(N_REQ - 1)) return '0;
    else                           return x + 1'b1;
  endfunction

  // Search rr_ptr, rr_ptr+1, ... modulo N_REQ for the first valid requester.
  // rr_ptr_q is always below N_REQ, so one conditional subtraction is enough to wrap.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!winner_found && in_valid[idx]) begin
        winner_found = 1'b1;
        winner       = idx[ID_WIDTH-1:0];
      end
    end
  end

  assign sel = (state_q == LOCKED) ? owner_q : winner;

  // When idle with no request, or while in reset, every output is forced low. No stale index or payload can leak out.
  assign active = !rst && ((state_q == LOCKED) || winner_found);

  always_comb begin
    in_ready  = '0;
    out_data  = '0;
    out_last  = 1'b0;
    out_id    = '0;
    out_valid = 1'b0;
    if (active) begin
      in_ready[sel] = out_ready;
      out_data      = in_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      out_last      = in_last[sel];
      out_id        = sel;
      out_valid     = in_valid[sel];
    end
  end

  assign hs   = out_valid && out_ready;
  assign busy = !rst && (state_q == LOCKED);

  // The arbiter locks as soon as a beat is presented, not only when it is accepted.
  // This keeps the selection stable while the FIFO is full, so out_valid never retracts a beat.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (winner_found) begin
          if (hs && in_last[winner]) begin
            rr_ptr_d = next_idx(winner);
          end else begin
            state_d = LOCKED;
            owner_d = winner;
          end
        end
      end
      LOCKED: begin
        if (hs && in_last[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_idx(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_dc_fifo_din_arbiter.sv
// Directed bench for dc_fifo_din_arbiter (N_REQ=4, DATA_WIDTH=10).
// Inputs change 1 ns after each rising edge. Outputs are sampled 1 ns later, well away from the edges.
// Expected values are hand-derived constants for each vector.
module tb_dc_fifo_din_arbiter;

  localparam int N   = 4;
  localparam int DW  = 10;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [IDW-1:0]  out_id;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  dc_fifo_din_arbiter #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_id   (out_id),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    in_data[i*DW +: DW] = v;
  endtask

  // Advance one clock; inputs may change on return.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Allow the combinational outputs to settle before sampling.
  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 10'h20 + 10'(i));

    // ---- Reset with every requester valid ----
    tick();
    settle();
    chk("rst_in_ready",  in_ready,  4'b0000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_out_id",    out_id,    0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_last",  out_last,  0);
    tick();
    rst = 1'b0;
    settle();

    // ---- Round robin over single-beat packets: 0,1,2,3,0 ----
    chk("rr0_id",       out_id,    0);
    chk("rr0_valid",    out_valid, 1);
    chk("rr0_in_ready", in_ready,  4'b0001);
    chk("rr0_data",     out_data,  10'h20);
    chk("rr0_busy",     busy,      0);
    tick(); settle();
    chk("rr1_id",   out_id,   1);
    chk("rr1_data", out_data, 10'h21);
    tick(); settle();
    chk("rr2_id",   out_id, 2);
    tick(); settle();
    chk("rr3_id",   out_id, 3);
    chk("rr3_busy", busy,   0);
    tick(); settle();
    chk("rr4_id",   out_id, 0);   // the pointer wraps from 3 back to 0
    tick();                       // rr_ptr is now 1

    // ---- Packet lock: req1 sends 3 beats while req2 waits ----
    in_valid = 4'b0110;
    in_last  = 4'b0100;
    set_data(1, 10'h11);
    set_data(2, 10'h22);
    settle();
    chk("lk1_id",       out_id,   1);
    chk("lk1_data",     out_data, 10'h11);
    chk("lk1_in_ready", in_ready, 4'b0010);
    tick();
    set_data(1, 10'h12);
    settle();
    chk("lk2_id",       out_id,   1);
    chk("lk2_data",     out_data, 10'h12);
    chk("lk2_busy",     busy,     1);
    chk("lk2_in_ready", in_ready, 4'b0010);
    tick();
    set_data(1, 10'h13);
    in_last = 4'b0110;
    settle();
    chk("lk3_id",   out_id,   1);
    chk("lk3_data", out_data, 10'h13);
    chk("lk3_last", out_last, 1);
    tick();
    in_valid = 4'b0100;
    settle();
    chk("lk_req2_id",       out_id,   2);
    chk("lk_req2_in_ready", in_ready, 4'b0100);
    chk("lk_req2_data",     out_data, 10'h22);
    tick();                       // req2 single beat taken, rr_ptr = 3

    // ---- Backpressure on the first beat of req0 ----
    in_valid  = 4'b0001;
    in_last   = 4'b0001;
    set_data(0, 10'h55);
    out_ready = 1'b0;
    settle();
    chk("bp0_id",       out_id,    0);
    chk("bp0_valid",    out_valid, 1);
    chk("bp0_in_ready", in_ready,  4'b0000);
    tick(); settle();
    chk("bp1_busy", busy,   1);
    chk("bp1_id",   out_id, 0);
    tick();
    in_valid = 4'b1001;           // req3 raises valid while req0 is stalled
    settle();
    chk("bp2_id",   out_id,   0);
    chk("bp2_data", out_data, 10'h55);
    chk("bp2_busy", busy,     1);
    tick(); settle();
    chk("bp3_id",       out_id,   0);
    chk("bp3_in_ready", in_ready, 4'b0000);
    tick();
    out_ready = 1'b1;
    settle();
    chk("bp_go_in_ready", in_ready, 4'b0001);
    chk("bp_go_id",       out_id,   0);
    tick();                       // req0 taken, rr_ptr = 1

    // ---- req3 two-beat packet with a valid gap, req0 waiting ----
    set_data(3, 10'h31);
    in_last = 4'b0001;
    settle();
    chk("gp1_id",   out_id,   3);
    chk("gp1_data", out_data, 10'h31);
    tick();
    in_valid = 4'b0001;           // owner drops valid
    settle();
    chk("gp_gap1_valid", out_valid,   0);
    chk("gp_gap1_busy",  busy,        1);
    chk("gp_gap1_id",    out_id,      3);
    chk("gp_gap1_rdy0",  in_ready[0], 0);
    tick(); settle();
    chk("gp_gap2_valid", out_valid,   0);
    chk("gp_gap2_rdy0",  in_ready[0], 0);
    tick();
    in_valid = 4'b1001;
    set_data(3, 10'h32);
    in_last  = 4'b1001;
    settle();
    chk("gp2_id",   out_id,   3);
    chk("gp2_data", out_data, 10'h32);
    chk("gp2_last", out_last, 1);
    tick();
    in_valid = 4'b0001;
    settle();
    chk("gp_wrap_id",   out_id, 0);   // rr_ptr wrapped to 0
    chk("gp_wrap_busy", busy,   0);
    tick();                           // req0 taken, rr_ptr = 1

    // ---- Reset in the middle of a req2 packet ----
    in_valid = 4'b0100;
    in_last  = 4'b0000;
    set_data(2, 10'h41);
    settle();
    chk("mr1_id", out_id, 2);
    tick();                           // beat 1 taken, locked on req2
    set_data(2, 10'h42);
    rst = 1'b1;
    settle();
    chk("mr_rst_valid",    out_valid, 0);
    chk("mr_rst_in_ready", in_ready,  4'b0000);
    chk("mr_rst_busy",     busy,      0);
    tick();
    rst      = 1'b0;
    in_valid = 4'b0101;
    in_last  = 4'b0101;
    set_data(0, 10'h0A);
    settle();
    chk("mr_after_busy", busy,     0);
    chk("mr_after_id",   out_id,   0);
    chk("mr_after_data", out_data, 10'h0A);
    chk("mr_after_rdy",  in_ready, 4'b0001);
    tick(); settle();
    chk("mr_next_id", out_id, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
